// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit for the MIPS32 EX stage.
// Multiply is shift-add over a 2*WIDTH accumulator; divide is restoring, one
// quotient bit per cycle. Results land in the architectural HI/LO registers.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start, op        begin op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU) from IDLE
//   a_data, b_data   operand A (multiplicand/dividend), operand B
//   abort            pipeline flush, kills an in-flight operation
//   hi_we, lo_we     MTHI/MTLO writes of wr_data, honoured in IDLE only
//   busy             operation in flight (CALC or FIX)
//   done             one-cycle pulse, HI/LO already hold the new result
//   hi, lo           HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt;
  logic                   is_div;
  logic                   sign_a, sign_b;
  logic [WIDTH-1:0]       op_a, op_b;
  logic [2*WIDTH-1:0]     acc, acc_nxt, prod;
  logic [WIDTH:0]         sum, diff;
  logic [WIDTH-1:0]       quot, rem, res_hi, res_lo;
  logic                   signed_op, last;
  logic [WIDTH-1:0]       a_abs, b_abs;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  assign signed_op = ~op[0];
  assign a_abs     = (signed_op && a_data[WIDTH-1]) ? -a_data : a_data;
  assign b_abs     = (signed_op && b_data[WIDTH-1]) ? -b_data : b_data;
  assign last      = (cnt == LAST_CNT);
  assign busy      = (state_q == CALC) || (state_q == FIX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = CALC;
      CALC:    if (abort) state_d = IDLE;
               else if (last) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration step. Multiply: acc = {partial, remaining multiplier bits},
  // add on LSB then shift right. Divide: acc = {remainder, dividend bits},
  // shift left and subtract when no borrow out of the WIDTH+1 difference.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
    diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_b};
    if (!is_div)
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
  end

  // Sign correction of the final iteration's output. The last CALC edge
  // writes HI/LO directly so the result is visible together with done in FIX.
  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
    quot = (sign_a ^ sign_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem  = sign_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      // Divide by zero leaves the dividend in the remainder naturally.
      res_hi = rem;
      res_lo = (op_b == '0) ? '1 : quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hi_we) hi <= wr_data;
          if (lo_we) lo <= wr_data;
          if (start && !abort) begin
            is_div <= op[1];
            sign_a <= signed_op & a_data[WIDTH-1];
            sign_b <= signed_op & b_data[WIDTH-1];
            op_a   <= a_abs;
            op_b   <= b_abs;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!abort) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              hi   <= res_hi;
              lo   <= res_lo;
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
